// File: rtl/sprite_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : sprite_scheduler_if
// Brief  : Draw-request handshake between the sprite scheduler and drawer.
// Rev    : 1.0  initial release
// ============================================================================
interface sprite_scheduler_if;
    logic       DS_Enable;
    logic [7:0] DS_X;
    logic [6:0] DS_Y;
    logic [2:0] DS_Sprite;
    logic [2:0] DS_AnimStep;
    logic [4:0] DS_Width;
    logic [4:0] DS_Height;
    logic       DS_Done;

    modport master (
        output DS_Enable, DS_X, DS_Y, DS_Sprite, DS_AnimStep, DS_Width, DS_Height,
        input  DS_Done
    );

    modport slave (
        input  DS_Enable, DS_X, DS_Y, DS_Sprite, DS_AnimStep, DS_Width, DS_Height,
        output DS_Done
    );
endinterface
`default_nettype wire

// File: rtl/sprite_scheduler.sv
`default_nettype none
// ============================================================================
// Module : sprite_scheduler
// Brief  : Walks the object table once per vblank, issuing one draw per entry.
// Rev    : 1.0  initial release
// ============================================================================
module sprite_scheduler #(
    parameter int NUM_OBJ    = 8,
    parameter int ANIM_DIV   = 4,
    parameter int ANIM_STEPS = 4
) (
    input  wire        Clock,
    input  wire        Resetn,
    input  wire        FrameStart,
    input  wire        WrEn,
    input  wire  [2:0] WrIdx,
    input  wire        WrValid,
    input  wire        WrAnim,
    input  wire  [7:0] WrX,
    input  wire  [6:0] WrY,
    input  wire  [2:0] WrSprite,
    input  wire  [4:0] WrWidth,
    input  wire  [4:0] WrHeight,
    sprite_scheduler_if.master ds,
    output logic [2:0] AnimStep,
    output logic       Busy,
    output logic       FrameDone,
    output logic       Overrun
);

    localparam logic [3:0] c_num_obj   = 4'(NUM_OBJ);
    localparam logic [2:0] c_last_idx  = 3'(NUM_OBJ - 1);
    localparam logic [7:0] c_div_last  = 8'(ANIM_DIV - 1);
    localparam logic [2:0] c_step_last = 3'(ANIM_STEPS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        ISSUE   = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4,
        FINISH  = 3'd5
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       anim;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] sprite;
        logic [4:0] width;
        logic [4:0] height;
    } entry_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] sprite;
        logic [2:0] step;
        logic [4:0] width;
        logic [4:0] height;
    } draw_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [2:0] anim_step_q, anim_step_d;
    draw_t      ds_q, ds_d;
    entry_t     tbl_q [8];
    entry_t     tbl_d [8];
    entry_t     w_cur;

    // Table is written in every state; out-of-range indices are dropped.
    always_comb begin
        tbl_d = tbl_q;
        if (WrEn && ({1'b0, WrIdx} < c_num_obj)) begin
            tbl_d[WrIdx] = '{valid: WrValid, anim: WrAnim, x: WrX, y: WrY,
                             sprite: WrSprite, width: WrWidth, height: WrHeight};
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        anim_step_d = anim_step_q;
        ds_d        = ds_q;
        w_cur       = tbl_q[idx_q];

        case (state_q)
            IDLE: begin
                if (FrameStart) begin
                    idx_d   = 3'd0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (w_cur.valid) begin
                    // A valid entry waits here until the drawer is idle.
                    if (ds.DS_Done) begin
                        state_d = ISSUE;
                        ds_d    = '{x: w_cur.x, y: w_cur.y, sprite: w_cur.sprite,
                                    step: w_cur.anim ? anim_step_q : 3'd0,
                                    width: w_cur.width, height: w_cur.height};
                    end
                end else if (idx_q == c_last_idx) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ISSUE: begin
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!ds.DS_Done) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (ds.DS_Done) begin
                    if (idx_q == c_last_idx) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SCAN;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (frame_cnt_q == c_div_last) begin
                    frame_cnt_d = 8'd0;
                    anim_step_d = (anim_step_q == c_step_last) ? 3'd0 : anim_step_q + 3'd1;
                end else begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            frame_cnt_q <= 8'd0;
            anim_step_q <= 3'd0;
            ds_q        <= '0;
            for (int i = 0; i < 8; i++) tbl_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            anim_step_q <= anim_step_d;
            ds_q        <= ds_d;
            for (int i = 0; i < 8; i++) tbl_q[i] <= tbl_d[i];
        end
    end

    assign ds.DS_Enable   = (state_q == ISSUE);
    assign ds.DS_X        = ds_q.x;
    assign ds.DS_Y        = ds_q.y;
    assign ds.DS_Sprite   = ds_q.sprite;
    assign ds.DS_AnimStep = ds_q.step;
    assign ds.DS_Width    = ds_q.width;
    assign ds.DS_Height   = ds_q.height;

    assign AnimStep  = anim_step_q;
    assign Busy      = (state_q != IDLE);
    assign FrameDone = (state_q == FINISH);
    // Any FrameStart outside IDLE, FINISH included, is dropped and flagged.
    assign Overrun   = FrameStart && (state_q != IDLE);

endmodule
`default_nettype wire
